// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared definitions for the two-requester memory arbiter:
//   - FSM state encoding (IDLE / START / WAIT_DONE / RELEASE)
//   - requester ID constants (INST = 0, DATA = 1)
//   - bus widths and the instruction-word select helper
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int BWE_W  = 8;
   localparam int INST_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      RELEASE   = 2'd3
   } state_t;

   // Requester IDs; also the encoding of the grant owner / last-grant flops.
   localparam logic INST = 1'b0;
   localparam logic DATA = 1'b1;

   // Picks the 32-bit instruction out of a 64-bit memory word using byte
   // address bit 2 (0 selects the low word, 1 the high word).
   function automatic logic [INST_W-1:0] select_inst_word(
      input logic [DATA_W-1:0] word,
      input logic              addr_bit2
   );
      logic [INST_W-1:0] sel;
      if (addr_bit2) begin
         sel = word[63:32];
      end else begin
         sel = word[31:0];
      end
      return sel;
   endfunction

endpackage : memory_arbiter_pkg

// File: rtl/memory_arbiter_round_robin_grant.sv
// -----------------------------------------------------------------------------
// round_robin_grant
// Two-way round-robin grant selector (purely combinational).
// Ports:
//   inst_req    - armed instruction request
//   data_req    - armed data request
//   last_grant  - ID of the requester granted most recently
//   grant_valid - at least one request present
//   grant_id    - ID of the selected requester (INST / DATA)
// -----------------------------------------------------------------------------
module round_robin_grant
   import memory_arbiter_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   // Grant selection: on a tie the requester not granted last wins.
   always_comb begin
      grant_valid = inst_req | data_req;
      grant_id    = INST;
      if (inst_req && data_req) begin
         if (last_grant == INST) begin
            grant_id = DATA;
         end else begin
            grant_id = INST;
         end
      end else if (data_req) begin
         grant_id = DATA;
      end else begin
         grant_id = INST;
      end
   end

endmodule : round_robin_grant

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. One access is in flight at a time; ties are broken round-robin.
// Ports:
//   clock, reset                    - clock, asynchronous active-low reset
//   inst_enable / inst_address      - fetch request and byte address
//   inst_busy / inst_read_data      - fetch in progress, fetched instruction
//   data_enable / data_address      - data request and byte address
//   data_byte_write_enable          - 0 = read, any bit set = write
//   data_write_data                 - store data
//   data_busy / data_read_data      - data access in progress, load data
//   mem_*                           - shared memory port
// -----------------------------------------------------------------------------
module memory_arbiter
   import memory_arbiter_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              inst_enable,
   input  logic [ADDR_W-1:0] inst_address,
   output logic              inst_busy,
   output logic [INST_W-1:0] inst_read_data,
   input  logic              data_enable,
   input  logic [ADDR_W-1:0] data_address,
   input  logic [BWE_W-1:0]  data_byte_write_enable,
   input  logic [DATA_W-1:0] data_write_data,
   output logic              data_busy,
   output logic [DATA_W-1:0] data_read_data,
   output logic              mem_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BWE_W-1:0]  mem_byte_write_enable,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_busy
);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              inst_armed_q, inst_armed_d;
   logic              data_armed_q, data_armed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BWE_W-1:0]  bwe_q, bwe_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [INST_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              inst_busy_q, inst_busy_d;
   logic              data_busy_q, data_busy_d;

   logic              inst_req_s;
   logic              data_req_s;
   logic              grant_valid_s;
   logic              grant_id_s;
   logic              grant_fire_s;
   logic              complete_s;
   logic              mem_active_s;

   // A request only competes while its requester is armed.
   assign inst_req_s = inst_enable & inst_armed_q;
   assign data_req_s = data_enable & data_armed_q;

   round_robin_grant u_grant (
      .inst_req    (inst_req_s),
      .data_req    (data_req_s),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

   assign grant_fire_s = (state_q == IDLE) && grant_valid_s;
   assign complete_s   = (state_q == WAIT_DONE) && !mem_busy;

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid_s) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (mem_busy) begin
               state_d = WAIT_DONE;
            end else begin
               state_d = START;
            end
         end
         WAIT_DONE: begin
            if (!mem_busy) begin
               state_d = RELEASE;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath next-state: grant latching, read-data capture, busy and arming.
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      bwe_d        = bwe_q;
      wdata_d      = wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_busy_d  = inst_busy_q;
      data_busy_d  = data_busy_q;

      if (grant_fire_s) begin
         owner_d      = grant_id_s;
         last_grant_d = grant_id_s;
         if (grant_id_s == DATA) begin
            addr_d      = data_address;
            bwe_d       = data_byte_write_enable;
            wdata_d     = data_write_data;
            data_busy_d = 1'b1;
         end else begin
            // Fetches are always reads.
            addr_d      = inst_address;
            bwe_d       = {BWE_W{1'b0}};
            wdata_d     = {DATA_W{1'b0}};
            inst_busy_d = 1'b1;
         end
      end else if (complete_s) begin
         if (owner_q == DATA) begin
            data_rdata_d = mem_read_data;
            data_busy_d  = 1'b0;
         end else begin
            // Word select is resolved now so the register stays valid after
            // the latched address is overwritten by a later grant.
            inst_rdata_d = select_inst_word(mem_read_data, addr_q[2]);
            inst_busy_d  = 1'b0;
         end
      end else begin
         owner_d = owner_q;
      end

      // Disarm at completion; re-arm only once the enable is seen low, so a
      // held enable cannot be granted a second time.
      if (complete_s && (owner_q == INST)) begin
         inst_armed_d = 1'b0;
      end else if (!inst_enable) begin
         inst_armed_d = 1'b1;
      end else begin
         inst_armed_d = inst_armed_q;
      end

      if (complete_s && (owner_q == DATA)) begin
         data_armed_d = 1'b0;
      end else if (!data_enable) begin
         data_armed_d = 1'b1;
      end else begin
         data_armed_d = data_armed_q;
      end
   end

   // Datapath registers; reset leaves both requesters armed with data preferred.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner_q      <= INST;
         last_grant_q <= INST;
         inst_armed_q <= 1'b1;
         data_armed_q <= 1'b1;
         addr_q       <= {ADDR_W{1'b0}};
         bwe_q        <= {BWE_W{1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         inst_rdata_q <= {INST_W{1'b0}};
         data_rdata_q <= {DATA_W{1'b0}};
         inst_busy_q  <= 1'b0;
         data_busy_q  <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         inst_armed_q <= inst_armed_d;
         data_armed_q <= data_armed_d;
         addr_q       <= addr_d;
         bwe_q        <= bwe_d;
         wdata_q      <= wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_busy_q  <= inst_busy_d;
         data_busy_q  <= data_busy_d;
      end
   end

   // FSM output decode: the memory port is driven only while an access is open.
   always_comb begin
      mem_active_s = (state_q == START) || (state_q == WAIT_DONE);
      if (mem_active_s) begin
         mem_enable            = 1'b1;
         mem_byte_write_enable = bwe_q;
      end else begin
         mem_enable            = 1'b0;
         mem_byte_write_enable = {BWE_W{1'b0}};
      end
   end

   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign inst_busy      = inst_busy_q;
   assign data_busy      = data_busy_q;
   assign inst_read_data = inst_rdata_q;
   assign data_read_data = data_rdata_q;

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed self-checking bench for memory_arbiter. The bench plays the memory
// side itself, stepping mem_busy / mem_read_data one cycle at a time.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   logic              clock;
   logic              reset;
   logic              inst_enable;
   logic [ADDR_W-1:0] inst_address;
   logic              inst_busy;
   logic [INST_W-1:0] inst_read_data;
   logic              data_enable;
   logic [ADDR_W-1:0] data_address;
   logic [BWE_W-1:0]  data_byte_write_enable;
   logic [DATA_W-1:0] data_write_data;
   logic              data_busy;
   logic [DATA_W-1:0] data_read_data;
   logic              mem_enable;
   logic [ADDR_W-1:0] mem_address;
   logic [BWE_W-1:0]  mem_byte_write_enable;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_busy;

   int checks   = 0;
   int failures = 0;

   memory_arbiter dut (
      .clock                  (clock),
      .reset                  (reset),
      .inst_enable            (inst_enable),
      .inst_address           (inst_address),
      .inst_busy              (inst_busy),
      .inst_read_data         (inst_read_data),
      .data_enable            (data_enable),
      .data_address           (data_address),
      .data_byte_write_enable (data_byte_write_enable),
      .data_write_data        (data_write_data),
      .data_busy              (data_busy),
      .data_read_data         (data_read_data),
      .mem_enable             (mem_enable),
      .mem_address            (mem_address),
      .mem_byte_write_enable  (mem_byte_write_enable),
      .mem_write_data         (mem_write_data),
      .mem_read_data          (mem_read_data),
      .mem_busy               (mem_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete access for the given owner, starting from IDLE with the
   // request already driven: grant, START, WAIT_DONE, RELEASE, back to IDLE.
   task automatic serve(input logic owner, input logic [63:0] addr, input logic [7:0] bwe,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [63:0] exp_rd, input logic drop);
      tick();
      check("grant_mem_enable", 64'(mem_enable), 64'd1);
      check("grant_owner_busy", 64'((owner == DATA) ? data_busy : inst_busy), 64'd1);
      check("grant_other_busy", 64'((owner == DATA) ? inst_busy : data_busy), 64'd0);
      check("grant_mem_address", mem_address, addr);
      check("grant_mem_bwe", 64'(mem_byte_write_enable), 64'(bwe));
      if (owner == DATA) begin
         check("grant_mem_wdata", mem_write_data, wdata);
      end
      mem_busy = 1'b1;
      tick();
      check("wait_mem_enable", 64'(mem_enable), 64'd1);
      check("wait_owner_busy", 64'((owner == DATA) ? data_busy : inst_busy), 64'd1);
      mem_busy      = 1'b0;
      mem_read_data = rdata;
      tick();
      check("release_owner_busy", 64'((owner == DATA) ? data_busy : inst_busy), 64'd0);
      check("release_mem_enable", 64'(mem_enable), 64'd0);
      check("release_mem_bwe", 64'(mem_byte_write_enable), 64'd0);
      check("release_read_data", (owner == DATA) ? data_read_data : 64'(inst_read_data), exp_rd);
      mem_read_data = 64'hFFFF_0000_FFFF_0000;
      if (drop) begin
         if (owner == DATA) begin
            data_enable = 1'b0;
         end else begin
            inst_enable = 1'b0;
         end
      end
      tick();
      check("idle_mem_enable", 64'(mem_enable), 64'd0);
   endtask

   initial begin
      reset                  = 1'b0;
      inst_enable            = 1'b0;
      inst_address           = 64'd0;
      data_enable            = 1'b0;
      data_address           = 64'd0;
      data_byte_write_enable = 8'h00;
      data_write_data        = 64'd0;
      mem_read_data          = 64'd0;
      mem_busy               = 1'b0;
      tick();
      tick();

      // Reset state.
      check("rst_mem_enable", 64'(mem_enable), 64'd0);
      check("rst_mem_bwe", 64'(mem_byte_write_enable), 64'd0);
      check("rst_mem_address", mem_address, 64'd0);
      check("rst_mem_wdata", mem_write_data, 64'd0);
      check("rst_inst_busy", 64'(inst_busy), 64'd0);
      check("rst_data_busy", 64'(data_busy), 64'd0);
      check("rst_inst_rdata", 64'(inst_read_data), 64'd0);
      check("rst_data_rdata", data_read_data, 64'd0);
      reset = 1'b1;
      tick();
      check("post_rst_idle", 64'(mem_enable), 64'd0);

      // Simultaneous requests after reset: data first, then instruction.
      inst_enable  = 1'b1;
      inst_address = 64'h1000;
      data_enable  = 1'b1;
      data_address = 64'h3000;
      serve(DATA, 64'h3000, 8'h00, 64'd0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b1);
      serve(INST, 64'h1000, 8'h00, 64'd0, 64'h5555_6666_7777_8888, 64'h7777_8888, 1'b1);

      // Data store alone.
      data_enable            = 1'b1;
      data_address           = 64'h2000;
      data_byte_write_enable = 8'h0F;
      data_write_data        = 64'h55;
      serve(DATA, 64'h2000, 8'h0F, 64'h55, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
      check("inst_rdata_hold", 64'(inst_read_data), 64'h7777_8888);
      data_byte_write_enable = 8'h00;
      data_write_data        = 64'd0;

      // Instruction fetch alone at 0x1004: high word selected.
      inst_enable  = 1'b1;
      inst_address = 64'h1004;
      serve(INST, 64'h1004, 8'h00, 64'd0, 64'hAABB_CCDD_1122_3344, 64'hAABB_CCDD, 1'b1);
      check("data_rdata_hold", data_read_data, 64'h0123_4567_89AB_CDEF);

      // Held data enable: no second access until it is sampled low.
      data_enable  = 1'b1;
      data_address = 64'h2008;
      serve(DATA, 64'h2008, 8'h00, 64'd0, 64'hCAFE_F00D_0000_0001, 64'hCAFE_F00D_0000_0001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("held_mem_enable", 64'(mem_enable), 64'd0);
         check("held_data_busy", 64'(data_busy), 64'd0);
      end
      data_enable = 1'b0;
      tick();
      check("held_drop_mem_enable", 64'(mem_enable), 64'd0);

      // Simultaneous again with data granted last: instruction wins.
      inst_enable            = 1'b1;
      inst_address           = 64'h100C;
      data_enable            = 1'b1;
      data_address           = 64'h4000;
      data_byte_write_enable = 8'hF0;
      data_write_data        = 64'hDEAD_BEEF_0000_0000;
      serve(INST, 64'h100C, 8'h00, 64'd0, 64'h9999_AAAA_BBBB_CCCC, 64'h9999_AAAA, 1'b1);
      serve(DATA, 64'h4000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h1357_9BDF_2468_ACE0,
            64'h1357_9BDF_2468_ACE0, 1'b1);
      data_byte_write_enable = 8'h00;
      data_write_data        = 64'd0;

      // Instruction request pulsed and dropped while data owns the port.
      data_enable  = 1'b1;
      data_address = 64'h5000;
      tick();
      check("drop_mem_address", mem_address, 64'h5000);
      inst_enable = 1'b1;
      mem_busy    = 1'b1;
      tick();
      inst_enable = 1'b0;
      check("drop_inst_busy", 64'(inst_busy), 64'd0);
      mem_busy      = 1'b0;
      mem_read_data = 64'h0BAD_0BAD_0BAD_0BAD;
      tick();
      data_enable = 1'b0;
      check("drop_data_busy", 64'(data_busy), 64'd0);
      tick();
      tick();
      check("drop_no_grant", 64'(mem_enable), 64'd0);
      check("drop_inst_idle", 64'(inst_busy), 64'd0);

      // Reset during WAIT_DONE abandons the access.
      data_enable  = 1'b1;
      data_address = 64'h6000;
      tick();
      mem_busy = 1'b1;
      tick();
      check("mid_wait_mem_enable", 64'(mem_enable), 64'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_mem_enable", 64'(mem_enable), 64'd0);
      check("mid_rst_data_busy", 64'(data_busy), 64'd0);
      check("mid_rst_data_rdata", data_read_data, 64'd0);
      check("mid_rst_mem_bwe", 64'(mem_byte_write_enable), 64'd0);
      data_enable   = 1'b0;
      mem_busy      = 1'b0;
      mem_read_data = 64'h7777_7777_7777_7777;
      tick();
      reset = 1'b1;
      tick();
      check("post_mid_rst_idle", 64'(mem_enable), 64'd0);
      inst_enable  = 1'b1;
      inst_address = 64'h1008;
      serve(INST, 64'h1008, 8'h00, 64'd0, 64'hFEDC_BA98_7654_3210, 64'h7654_3210, 1'b1);
      check("post_mid_rst_data_rdata", data_read_data, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_memory_arbiter
